async_handshake_txq: RTL and testbench

Transmit-side queue placed directly upstream of `async_handshake`, in the `async_handshake` transmit clock domain. It accepts bytes from a local producer over a valid/ready interface and stores them in a DEPTH-entry FIFO. It then drains the FIFO one entry at a time into `async_handshake`: a one-cycle `hs_valid` pulse is issued only when the synchronizer reports ready, and the queue then waits for the full busy/ready cycle to complete. Producers can burst data without tracking the multi-cycle cross-domain handshake latency.

---
 rtl/async_handshake_txq.sv | 124 ++++++++++++
 tb/tb_async_handshake_txq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/async_handshake_txq.sv
`default_nettype none
// ============================================================================
// async_handshake_txq : FIFO that drains bytes into async_handshake, one
//                       hs_valid pulse per full busy/ready cycle of hs_ready.
// Revision: 1.0
// ============================================================================
module async_handshake_txq #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [DW-1:0]                in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DW-1:0]                hs_data,
  output logic                         hs_valid,
  input  logic                         hs_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_LOW  = 2'd1;
  localparam logic [1:0] S_WAIT_HIGH = 2'd2;

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] hs_data_q, hs_data_d;
  logic          hs_valid_q, hs_valid_d;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  always_comb begin
    w_full  = (count_q == CW'(DEPTH));
    w_empty = (count_q == '0);
    w_push  = in_valid && !w_full;
    // A launch only ever starts from IDLE, which guarantees the previous
    // pulse saw its complete low->high hs_ready cycle.
    w_pop   = (state_q == S_IDLE) && !w_empty && hs_ready;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    hs_data_d  = hs_data_q;
    hs_valid_d = 1'b0;

    if (w_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (w_pop) begin
          hs_data_d  = mem_q[rd_ptr_q];
          hs_valid_d = 1'b1;
          rd_ptr_d   = rd_ptr_q + 1'b1;
          state_d    = S_WAIT_LOW;
        end
      end
      S_WAIT_LOW: begin
        if (!hs_ready) begin
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (hs_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= S_IDLE;
      hs_data_q  <= '0;
      hs_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      hs_data_q  <= hs_data_d;
      hs_valid_q <= hs_valid_d;
    end
  end

  // Storage needs no reset: occupancy and pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign in_ready = !w_full;
  assign hs_data  = hs_data_q;
  assign hs_valid = hs_valid_q;
  assign count    = count_q;
  assign busy     = (state_q != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_async_handshake_txq.sv
`default_nettype none
// ============================================================================
// tb_async_handshake_txq : directed self-checking bench for async_handshake_txq.
// Revision: 1.0
// ============================================================================
module tb_async_handshake_txq;

  logic       clk;
  logic       rst_b;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] hs_data;
  logic       hs_valid;
  logic       hs_ready;
  logic [2:0] count;
  logic       busy;

  int checks;
  int failures;

  async_handshake_txq #(.DW(8), .DEPTH(4)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .hs_data  (hs_data),
    .hs_valid (hs_valid),
    .hs_ready (hs_ready),
    .count    (count),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_b    = 1'b0;
    in_data  = 8'h00;
    in_valid = 1'b0;
    hs_ready = 1'b0;
    repeat (3) tick();
    checks++; if (hs_valid !== 1'b0) begin failures++; $display("FAIL reset_hs_valid got=%b exp=0", hs_valid); end
    checks++; if (hs_data !== 8'h00) begin failures++; $display("FAIL reset_hs_data got=%h exp=00", hs_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_b = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    hs_ready = 1'b1;
    in_data  = 8'h55;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count_after_push got=%0d exp=1", count); end
    checks++; if (hs_valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%b exp=0", hs_valid); end
    tick();
    checks++; if (hs_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", hs_valid); end
    checks++; if (hs_data !== 8'h55) begin failures++; $display("FAIL single_data got=%h exp=55", hs_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL single_count_after_pop got=%0d exp=0", count); end
    tick();
    checks++; if (hs_valid !== 1'b0) begin failures++; $display("FAIL single_pulse_width got=%b exp=0", hs_valid); end
    hs_ready = 1'b0;
    repeat (4) tick();
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_low got=%b exp=1", busy); end
    hs_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_fall got=%b exp=0", busy); end
    checks++; if (hs_data !== 8'h55) begin failures++; $display("FAIL single_data_hold got=%h exp=55", hs_data); end
  endtask

  task automatic test_fill_to_full();
    logic [7:0] vals [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h66;
    hs_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      in_data  = vals[i];
      in_valid = 1'b1;
      tick();
      checks++; if (hs_valid !== 1'b0) begin failures++; $display("FAIL fill_no_valid idx=%0d got=%b exp=0", i, hs_valid); end
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b exp=0", in_ready); end
  endtask

  task automatic test_drain_order();
    logic [7:0] exp_vals [4];
    int n;
    int low_left;
    int last_cycle;
    logic prev_ready;
    exp_vals[0] = 8'h11; exp_vals[1] = 8'h22; exp_vals[2] = 8'h33; exp_vals[3] = 8'h44;
    n = 0;
    low_left = 0;
    last_cycle = 0;
    hs_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      prev_ready = hs_ready;
      tick();
      if (hs_valid === 1'b1) begin
        checks++; if (prev_ready !== 1'b1) begin failures++; $display("FAIL drain_pulse_while_low cyc=%0d got=0 exp=1", cyc); end
        if (n < 4) begin
          checks++; if (hs_data !== exp_vals[n]) begin failures++; $display("FAIL drain_data idx=%0d got=%h exp=%h", n, hs_data, exp_vals[n]); end
        end
        if (n == 0) begin
          checks++; if (count !== 3'd3) begin failures++; $display("FAIL drain_first_count got=%0d exp=3", count); end
          checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL drain_in_ready got=%b exp=1", in_ready); end
        end else begin
          checks++; if (cyc - last_cycle != 8) begin failures++; $display("FAIL drain_gap idx=%0d got=%0d exp=8", n, cyc - last_cycle); end
        end
        last_cycle = cyc;
        n++;
        hs_ready = 1'b0;
        low_left = 6;
      end else if (low_left > 0) begin
        low_left--;
        if (low_left == 0) hs_ready = 1'b1;
      end
    end
    checks++; if (n !== 4) begin failures++; $display("FAIL drain_pulse_count got=%0d exp=4", n); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL drain_final_count got=%0d exp=0", count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_final_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    hs_ready = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h80;
    tick();
    in_data  = 8'h81;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_setup_count got=%0d exp=2", count); end
    hs_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data  = 8'h80 + 8'(i + 2);
      in_valid = 1'b1;
      tick();
      checks++; if (hs_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid iter=%0d got=%b exp=1", i, hs_valid); end
      checks++; if (hs_data !== 8'h80 + 8'(i)) begin failures++; $display("FAIL b2b_data iter=%0d got=%h exp=%h", i, hs_data, 8'h80 + 8'(i)); end
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count iter=%0d got=%0d exp=2", i, count); end
      in_valid = 1'b0;
      hs_ready = 1'b0;
      tick();
      hs_ready = 1'b1;
      tick();
    end
  endtask

  task automatic test_reset_mid_operation();
    // Launch 0x8A while pushing 0x8C, then push 0x8D as the FSM reaches WAIT_HIGH.
    in_data  = 8'h8C;
    in_valid = 1'b1;
    tick();
    checks++; if (hs_data !== 8'h8A) begin failures++; $display("FAIL mid_pre_data got=%h exp=8a", hs_data); end
    hs_ready = 1'b0;
    in_data  = 8'h8D;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", count); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_pre_busy got=%b exp=1", busy); end
    #2;
    rst_b = 1'b0;
    #1;
    checks++; if (hs_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_hs_valid got=%b exp=0", hs_valid); end
    checks++; if (hs_data !== 8'h00) begin failures++; $display("FAIL mid_rst_hs_data got=%h exp=00", hs_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_rst_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
    tick();
    rst_b    = 1'b1;
    hs_ready = 1'b1;
    tick();
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL mid_post_count got=%0d exp=1", count); end
    tick();
    checks++; if (hs_valid !== 1'b1) begin failures++; $display("FAIL mid_post_valid got=%b exp=1", hs_valid); end
    checks++; if (hs_data !== 8'hA5) begin failures++; $display("FAIL mid_post_data got=%h exp=a5", hs_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL mid_post_count_drained got=%0d exp=0", count); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_byte();
    test_fill_to_full();
    test_drain_order();
    test_back_to_back();
    test_reset_mid_operation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
